// File: rtl/b16_ser_master.sv
// ---------------------------------------------------------------------------
// b16_ser_master
//
// Byte-stream initiator for the b16 memory bus. A host sends short commands
// over an 8-bit rx/tx byte link (typically from a UART). Each command becomes
// one word or byte transfer on the b16 bus, after the bus is obtained from the
// arbiter. The block sits beside the CPU as a second bus master. Typical uses
// are loading boot images into SRAM and inspecting memory.
//
// Commands (arguments MSB first):
//   0x52 'R' aH aL        word read  -> reply dataH, dataL
//   0x4E 'N'              word read at last address + 2 -> reply dataH, dataL
//   0x57 'W' aH aL dH dL  word write -> reply 0x2E
//   0x42 'B' aH aL d      byte write -> reply 0x2E
//   other                 no bus activity -> reply 0x3F
//   A transfer that times out replies 0x21 instead.
//
// Ports:
//   clk       : clock, rising edge
//   nreset    : synchronous active-low reset
//   rx_data   : received byte, qualified by rx_valid
//   rx_valid  : one-cycle strobe, no backpressure
//   tx_data   : byte to send, qualified by tx_valid
//   tx_valid  : tx_data valid
//   tx_ready  : sink accepts when tx_valid & tx_ready
//   bus_req   : bus request to the arbiter
//   bus_gnt   : bus grant from the arbiter
//   addr      : bus byte address
//   r         : read strobe
//   w         : byte write enables (w[1] -> dwrite[15:8], w[0] -> dwrite[7:0])
//   dwrite    : write data
//   data      : read data
//   ready     : responder completes the transfer at this edge
//   overrun   : sticky; a byte arrived while busy (cleared only by reset)
//
// Parameter:
//   TO_BITS   : timeout counter width; a transfer aborts after
//               2^TO_BITS-1 cycles without ready
// ---------------------------------------------------------------------------
module b16_ser_master #(
    parameter int unsigned TO_BITS = 8
) (
    input  logic        clk,
    input  logic        nreset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        bus_req,
    input  logic        bus_gnt,
    output logic [15:0] addr,
    output logic        r,
    output logic [1:0]  w,
    output logic [15:0] dwrite,
    input  logic [15:0] data,
    input  logic        ready,
    output logic        overrun
);

    localparam logic [7:0] CMD_R   = 8'h52;
    localparam logic [7:0] CMD_N   = 8'h4E;
    localparam logic [7:0] CMD_W   = 8'h57;
    localparam logic [7:0] CMD_B   = 8'h42;
    localparam logic [7:0] RSP_OK  = 8'h2E;
    localparam logic [7:0] RSP_UNK = 8'h3F;
    localparam logic [7:0] RSP_TO  = 8'h21;

    // The counter starts at 0 in the first XFER cycle. Aborting when it holds
    // 2^TO_BITS-2 therefore ends the transfer after exactly 2^TO_BITS-1
    // cycles without ready.
    localparam logic [TO_BITS-1:0] TO_ONE  = TO_BITS'(1);
    localparam logic [TO_BITS-1:0] TO_LAST = ~TO_ONE;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ARG  = 3'd1,
        ST_REQ  = 3'd2,
        ST_XFER = 3'd3,
        ST_RESP = 3'd4
    } state_t;

    // Number of argument bytes that follow a command byte (0 = none/unknown).
    function automatic logic [2:0] arg_count(input logic [7:0] cmd);
        logic [2:0] n;
        case (cmd)
            CMD_R:   n = 3'd2;
            CMD_W:   n = 3'd4;
            CMD_B:   n = 3'd3;
            default: n = 3'd0;
        endcase
        return n;
    endfunction

    state_t              state_r;
    logic [7:0]          cmd_r;
    logic [2:0]          arg_left_r;
    logic [23:0]         arg_r;        // previously received argument bytes
    logic [15:0]         last_addr_r;  // address of the last transfer
    logic [15:0]         xfer_addr_r;
    logic [15:0]         xfer_data_r;
    logic [1:0]          xfer_wen_r;
    logic                xfer_rd_r;
    logic [TO_BITS-1:0]  to_cnt_r;
    logic [7:0]          resp_lo_r;    // second response byte of a read
    logic                resp_two_r;   // a second response byte is pending

    logic [31:0]         full_s;
    logic [15:0]         dec_addr_s;
    logic [15:0]         dec_data_s;
    logic [1:0]          dec_wen_s;
    logic                dec_rd_s;
    logic [15:0]         next_addr_s;

    // Decode the complete argument set as the final argument byte arrives.
    always_comb begin
        full_s      = {arg_r, rx_data};
        dec_addr_s  = 16'h0000;
        dec_data_s  = 16'h0000;
        dec_wen_s   = 2'b00;
        dec_rd_s    = 1'b0;
        next_addr_s = (last_addr_r & 16'hFFFE) + 16'h0002;
        case (cmd_r)
            CMD_R: begin
                dec_addr_s = full_s[15:0] & 16'hFFFE;
                dec_rd_s   = 1'b1;
            end
            CMD_W: begin
                dec_addr_s = full_s[31:16] & 16'hFFFE;
                dec_data_s = full_s[15:0];
                dec_wen_s  = 2'b11;
            end
            CMD_B: begin
                // Big-endian: the even address is the high byte lane.
                dec_addr_s = full_s[23:8];
                dec_data_s = {full_s[7:0], full_s[7:0]};
                if (full_s[8]) begin
                    dec_wen_s = 2'b01;
                end else begin
                    dec_wen_s = 2'b10;
                end
            end
            default: begin
                dec_addr_s = 16'h0000;
            end
        endcase
    end

    // Command FSM with registered bus and byte-link outputs.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            state_r     <= ST_IDLE;
            cmd_r       <= 8'h00;
            arg_left_r  <= 3'd0;
            arg_r       <= 24'h000000;
            last_addr_r <= 16'h0000;
            xfer_addr_r <= 16'h0000;
            xfer_data_r <= 16'h0000;
            xfer_wen_r  <= 2'b00;
            xfer_rd_r   <= 1'b0;
            to_cnt_r    <= '0;
            resp_lo_r   <= 8'h00;
            resp_two_r  <= 1'b0;
            tx_data     <= 8'h00;
            tx_valid    <= 1'b0;
            bus_req     <= 1'b0;
            addr        <= 16'h0000;
            r           <= 1'b0;
            w           <= 2'b00;
            dwrite      <= 16'h0000;
            overrun     <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (rx_valid) begin
                        cmd_r <= rx_data;
                        if (rx_data == CMD_N) begin
                            state_r     <= ST_REQ;
                            bus_req     <= 1'b1;
                            xfer_addr_r <= next_addr_s;
                            last_addr_r <= next_addr_s;
                            xfer_data_r <= 16'h0000;
                            xfer_wen_r  <= 2'b00;
                            xfer_rd_r   <= 1'b1;
                        end else if (arg_count(rx_data) != 3'd0) begin
                            state_r    <= ST_ARG;
                            arg_left_r <= arg_count(rx_data);
                        end else begin
                            state_r    <= ST_RESP;
                            tx_valid   <= 1'b1;
                            tx_data    <= RSP_UNK;
                            resp_two_r <= 1'b0;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_ARG: begin
                    if (rx_valid) begin
                        arg_r <= {arg_r[15:0], rx_data};
                        if (arg_left_r == 3'd1) begin
                            state_r     <= ST_REQ;
                            bus_req     <= 1'b1;
                            xfer_addr_r <= dec_addr_s;
                            last_addr_r <= dec_addr_s;
                            xfer_data_r <= dec_data_s;
                            xfer_wen_r  <= dec_wen_s;
                            xfer_rd_r   <= dec_rd_s;
                        end else begin
                            arg_left_r <= arg_left_r - 3'd1;
                        end
                    end else begin
                        state_r <= ST_ARG;
                    end
                end
                ST_REQ: begin
                    if (rx_valid) begin
                        overrun <= 1'b1;
                    end else begin
                        overrun <= overrun;
                    end
                    if (bus_gnt) begin
                        state_r  <= ST_XFER;
                        addr     <= xfer_addr_r;
                        r        <= xfer_rd_r;
                        w        <= xfer_wen_r;
                        dwrite   <= xfer_data_r;
                        to_cnt_r <= '0;
                    end else begin
                        state_r <= ST_REQ;
                    end
                end
                ST_XFER: begin
                    if (rx_valid) begin
                        overrun <= 1'b1;
                    end else begin
                        overrun <= overrun;
                    end
                    if (ready || (to_cnt_r == TO_LAST)) begin
                        state_r  <= ST_RESP;
                        bus_req  <= 1'b0;
                        addr     <= 16'h0000;
                        r        <= 1'b0;
                        w        <= 2'b00;
                        dwrite   <= 16'h0000;
                        tx_valid <= 1'b1;
                        if (!ready) begin
                            tx_data    <= RSP_TO;
                            resp_two_r <= 1'b0;
                        end else if (xfer_rd_r) begin
                            tx_data    <= data[15:8];
                            resp_lo_r  <= data[7:0];
                            resp_two_r <= 1'b1;
                        end else begin
                            tx_data    <= RSP_OK;
                            resp_two_r <= 1'b0;
                        end
                    end else begin
                        to_cnt_r <= to_cnt_r + TO_ONE;
                    end
                end
                ST_RESP: begin
                    if (rx_valid) begin
                        overrun <= 1'b1;
                    end else begin
                        overrun <= overrun;
                    end
                    if (tx_ready) begin
                        if (resp_two_r) begin
                            tx_data    <= resp_lo_r;
                            resp_two_r <= 1'b0;
                        end else begin
                            state_r  <= ST_IDLE;
                            tx_valid <= 1'b0;
                            tx_data  <= 8'h00;
                        end
                    end else begin
                        state_r <= ST_RESP;
                    end
                end
                default: begin
                    state_r  <= ST_IDLE;
                    tx_valid <= 1'b0;
                    bus_req  <= 1'b0;
                    addr     <= 16'h0000;
                    r        <= 1'b0;
                    w        <= 2'b00;
                    dwrite   <= 16'h0000;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_b16_ser_master.sv
// ---------------------------------------------------------------------------
// tb_b16_ser_master
//
// Directed bench for b16_ser_master (TO_BITS = 4). Inputs change 1 time unit
// after each rising edge. Outputs are sampled at the same point, so each
// sample shows the values of the cycle that follows the edge.
// ---------------------------------------------------------------------------
module tb_b16_ser_master;

    logic        clk;
    logic        nreset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        bus_req;
    logic        bus_gnt;
    logic [15:0] addr;
    logic        r;
    logic [1:0]  w;
    logic [15:0] dwrite;
    logic [15:0] data;
    logic        ready;
    logic        overrun;

    int n_checks;
    int n_errors;

    b16_ser_master #(.TO_BITS(4)) dut (
        .clk      (clk),
        .nreset   (nreset),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .bus_req  (bus_req),
        .bus_gnt  (bus_gnt),
        .addr     (addr),
        .r        (r),
        .w        (w),
        .dwrite   (dwrite),
        .data     (data),
        .ready    (ready),
        .overrun  (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        step();
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    // Wait (bounded) for a response byte, check it, let it handshake.
    task automatic expect_tx(input string tag, input logic [7:0] exp);
        int k;
        k = 0;
        while (!tx_valid && k < 40) begin
            step();
            k++;
        end
        check({tag, "_valid"}, {31'd0, tx_valid}, 32'd1);
        check(tag, {24'd0, tx_data}, {24'd0, exp});
        step();
    endtask

    // Called right after the last command byte. Grants at once, holds ready
    // low for rdy_dly cycles, then completes with rdata.
    task automatic run_xfer(input string tag, input logic [15:0] e_addr, input logic e_r,
                            input logic [1:0] e_w, input logic [15:0] e_dw,
                            input int rdy_dly, input logic [15:0] rdata);
        check({tag, "_req"}, {31'd0, bus_req}, 32'd1);
        check({tag, "_req_idle"}, {15'd0, r, w, addr}, 32'd0);
        bus_gnt = 1'b1;
        step();
        bus_gnt = 1'b0;
        check({tag, "_addr"}, {16'd0, addr}, {16'd0, e_addr});
        check({tag, "_r"}, {31'd0, r}, {31'd0, e_r});
        check({tag, "_w"}, {30'd0, w}, {30'd0, e_w});
        check({tag, "_dwrite"}, {16'd0, dwrite}, {16'd0, e_dw});
        for (int i = 0; i < rdy_dly; i++) begin
            step();
            check({tag, "_hold"}, {r, w, addr, dwrite[12:0]}, {e_r, e_w, e_addr, e_dw[12:0]});
        end
        ready = 1'b1;
        data  = rdata;
        step();
        ready = 1'b0;
        data  = 16'h0000;
        check({tag, "_done_strobes"}, {13'd0, bus_req, r, w, addr}, 32'd0);
        check({tag, "_done_txv"}, {31'd0, tx_valid}, 32'd1);
    endtask

    initial begin
        int cnt;
        n_checks = 0;
        n_errors = 0;
        nreset   = 1'b0;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        tx_ready = 1'b1;
        bus_gnt  = 1'b0;
        data     = 16'h0000;
        ready    = 1'b0;
        step();
        step();
        check("rst_outputs", {tx_valid, tx_data, bus_req, r, w, addr[12:0]}, 32'd0);
        check("rst_dwrite_ovr", {15'd0, overrun, dwrite}, 32'd0);
        nreset = 1'b1;
        step();

        // 'N' straight after reset reads 0x0002.
        send_byte(8'h4E);
        run_xfer("n_rst", 16'h0002, 1'b1, 2'b00, 16'h0000, 0, 16'h1111);
        expect_tx("n_rst_hi", 8'h11);
        expect_tx("n_rst_lo", 8'h11);

        // Word write, ready 3 cycles after the strobes appear.
        send_byte(8'h57); send_byte(8'h20); send_byte(8'h00);
        send_byte(8'h12); send_byte(8'h34);
        run_xfer("wr", 16'h2000, 1'b0, 2'b11, 16'h1234, 3, 16'h0000);
        expect_tx("wr_ack", 8'h2E);
        check("wr_txv_off", {30'd0, tx_valid, bus_req}, 32'd0);

        // Word read with odd address, aligned down.
        send_byte(8'h52); send_byte(8'h20); send_byte(8'h01);
        run_xfer("rd", 16'h2000, 1'b1, 2'b00, 16'h0000, 1, 16'hBEEF);
        expect_tx("rd_hi", 8'hBE);
        expect_tx("rd_lo", 8'hEF);

        // 'N' continues at 0x2002; tx_ready held low 5 cycles.
        tx_ready = 1'b0;
        send_byte(8'h4E);
        run_xfer("nxt", 16'h2002, 1'b1, 2'b00, 16'h0000, 0, 16'hCAFE);
        for (int i = 0; i < 5; i++) begin
            check("bp_hold", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, 8'hCA});
            step();
        end
        tx_ready = 1'b1;
        check("bp_still_hi", {24'd0, tx_data}, 32'h000000CA);
        step();
        expect_tx("bp_lo", 8'hFE);

        // Byte writes: odd address -> low lane, even -> high lane.
        send_byte(8'h42); send_byte(8'h00); send_byte(8'h05); send_byte(8'hAA);
        run_xfer("bodd", 16'h0005, 1'b0, 2'b01, 16'hAAAA, 0, 16'h0000);
        expect_tx("bodd_ack", 8'h2E);
        send_byte(8'h42); send_byte(8'h00); send_byte(8'h04); send_byte(8'h55);
        run_xfer("bev", 16'h0004, 1'b0, 2'b10, 16'h5555, 0, 16'h0000);
        expect_tx("bev_ack", 8'h2E);

        // Address wrap.
        send_byte(8'h52); send_byte(8'hFF); send_byte(8'hFE);
        run_xfer("rdtop", 16'hFFFE, 1'b1, 2'b00, 16'h0000, 0, 16'h1234);
        expect_tx("rdtop_hi", 8'h12);
        expect_tx("rdtop_lo", 8'h34);
        send_byte(8'h4E);
        run_xfer("wrap", 16'h0000, 1'b1, 2'b00, 16'h0000, 0, 16'h5678);
        expect_tx("wrap_hi", 8'h56);
        expect_tx("wrap_lo", 8'h78);

        // Unknown command.
        send_byte(8'h7A);
        check("unk_noreq", {31'd0, bus_req}, 32'd0);
        expect_tx("unk_resp", 8'h3F);
        check("unk_noreq2", {31'd0, bus_req}, 32'd0);

        // Timeout: ready never comes, strobes last 15 cycles.
        send_byte(8'h57); send_byte(8'h30); send_byte(8'h00);
        send_byte(8'hAB); send_byte(8'hCD);
        check("to_req", {31'd0, bus_req}, 32'd1);
        bus_gnt = 1'b1;
        step();
        bus_gnt = 1'b0;
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            if (w == 2'b00) break;
            cnt++;
            step();
        end
        check("to_cycles", cnt, 32'd15);
        check("to_addr_off", {16'd0, addr}, 32'd0);
        expect_tx("to_resp", 8'h21);

        // Overrun: byte arrives during XFER.
        check("ovr_before", {31'd0, overrun}, 32'd0);
        send_byte(8'h52); send_byte(8'h00); send_byte(8'h10);
        bus_gnt = 1'b1;
        step();
        bus_gnt = 1'b0;
        check("ovr_r", {31'd0, r}, 32'd1);
        send_byte(8'h99);
        check("ovr_set", {31'd0, overrun}, 32'd1);
        ready = 1'b1;
        data  = 16'h5A5A;
        step();
        ready = 1'b0;
        data  = 16'h0000;
        expect_tx("ovr_hi", 8'h5A);
        expect_tx("ovr_lo", 8'h5A);
        check("ovr_sticky", {31'd0, overrun}, 32'd1);

        // Reset mid-XFER.
        send_byte(8'h57); send_byte(8'h40); send_byte(8'h00);
        send_byte(8'h00); send_byte(8'h01);
        bus_gnt = 1'b1;
        step();
        bus_gnt = 1'b0;
        check("mid_w", {30'd0, w}, 32'd3);
        nreset = 1'b0;
        step();
        nreset = 1'b1;
        check("mid_rst_out", {tx_valid, tx_data, bus_req, r, w, addr[12:0]}, 32'd0);
        check("mid_rst_dw_ovr", {15'd0, overrun, dwrite}, 32'd0);
        step();
        send_byte(8'h4E);
        run_xfer("mid_n", 16'h0002, 1'b1, 2'b00, 16'h0000, 0, 16'h0F0F);
        expect_tx("mid_n_hi", 8'h0F);
        expect_tx("mid_n_lo", 8'h0F);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
